// File: rtl/uart_rx_oversampled_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_oversampled_pkg
//  Description : Shared UART types and default frame constants (RX and TX).
//  Revision    : 1.0  initial release
// ============================================================================
package uart_rx_oversampled_pkg;

    localparam int c_DATA_BITS  = 8;
    localparam int c_OVERSAMPLE = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } uart_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_oversampled_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_oversampled_if
//  Description : Receiver-to-system word handshake plus error/status flags.
//  Revision    : 1.0  initial release
// ============================================================================
interface uart_rx_oversampled_if
    import uart_rx_oversampled_pkg::*;
#(
    parameter int DATA_BITS = c_DATA_BITS
);
    logic [DATA_BITS-1:0] rx_data;
    logic                 rx_valid;
    logic                 rx_ready;
    logic                 frame_err;
    logic                 parity_err;
    logic                 overrun;
    logic                 busy;

    // Receiver side: produces words and flags
    modport master (
        output rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        input  rx_ready
    );

    // Consumer side: accepts words
    modport slave (
        input  rx_data, rx_valid, frame_err, parity_err, overrun, busy,
        output rx_ready
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_oversampled_sync.sv
`default_nettype none
// ============================================================================
//  Module      : uart_sync
//  Description : 2-FF synchronizer; output is either the synchronized level
//                or a 1-clk pulse on its rising edge.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_sync
    import uart_rx_oversampled_pkg::*;
#(
    parameter logic RESET_VAL = 1'b0,
    parameter bit   EDGE      = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_d,
    output logic      o_q
);

    logic r_meta;
    logic r_sync;

    // Two-stage capture of the asynchronous input
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    generate
        if (EDGE) begin : g_edge
            logic r_prev;

            // Delayed copy for rising-edge detection
            always_ff @(posedge clk) begin
                if (rst) r_prev <= RESET_VAL;
                else     r_prev <= r_sync;
            end

            assign o_q = r_sync & ~r_prev;
        end else begin : g_level
            assign o_q = r_sync;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_oversampled
//  Description : Oversampled async serial receiver (start + data LSB-first +
//                optional parity + 1 stop) with valid/ready word output.
//  Revision    : 1.0  initial release
// ============================================================================
module uart_rx_oversampled
    import uart_rx_oversampled_pkg::*;
#(
    parameter int DATA_BITS  = c_DATA_BITS,
    parameter int OVERSAMPLE = c_OVERSAMPLE,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              os_clk,
    input  wire logic              rx,
    uart_rx_oversampled_if.master  io_bus
);

    localparam int           c_OW       = $clog2(OVERSAMPLE);
    localparam int           c_BW       = $clog2(DATA_BITS + 1);
    localparam logic [c_OW-1:0] c_OS_MID  = c_OW'(OVERSAMPLE / 2 - 1);
    localparam logic [c_OW-1:0] c_OS_LAST = c_OW'(OVERSAMPLE - 1);
    localparam logic [c_BW-1:0] c_BIT_LAST = c_BW'(DATA_BITS - 1);
    localparam logic         c_PAR_EN   = (PARITY_EN != 0);
    localparam logic         c_PAR_ODD  = (PARITY_ODD != 0);

    logic w_rx_s;
    logic w_tick;

    uart_sync #(.RESET_VAL(1'b1), .EDGE(1'b0)) u_sync_rx (
        .clk (clk),
        .rst (rst),
        .i_d (rx),
        .o_q (w_rx_s)
    );

    uart_sync #(.RESET_VAL(1'b0), .EDGE(1'b1)) u_sync_os (
        .clk (clk),
        .rst (rst),
        .i_d (os_clk),
        .o_q (w_tick)
    );

    uart_state_e          r_state;
    uart_state_e          w_state_next;
    logic [c_OW-1:0]      r_os_cnt;
    logic [c_BW-1:0]      r_bit_cnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_par_ok;
    logic [DATA_BITS-1:0] r_rx_data;
    logic                 r_rx_valid;
    logic                 r_frame_err;
    logic                 r_parity_err;
    logic                 r_overrun;

    logic w_os_clr;
    logic w_os_inc;
    logic w_bit_clr;
    logic w_shift;
    logic w_par_chk;
    logic w_load;
    logic w_ferr;
    logic w_perr;
    logic w_exp_par;
    logic w_accept;

    // Even parity is the XOR of all data bits; odd parity inverts it
    assign w_exp_par = (^r_shift) ^ c_PAR_ODD;
    assign w_accept  = r_rx_valid & io_bus.rx_ready;

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_next;
    end

    // Next-state and datapath strobes; nothing advances without a tick
    always_comb begin
        w_state_next = r_state;
        w_os_clr     = 1'b0;
        w_os_inc     = 1'b0;
        w_bit_clr    = 1'b0;
        w_shift      = 1'b0;
        w_par_chk    = 1'b0;
        w_load       = 1'b0;
        w_ferr       = 1'b0;
        w_perr       = 1'b0;
        if (w_tick) begin
            case (r_state)
                ST_IDLE: begin
                    if (!w_rx_s) begin
                        w_state_next = ST_START;
                        w_os_clr     = 1'b1;
                    end
                end
                ST_START: begin
                    if (r_os_cnt == c_OS_MID) begin
                        if (w_rx_s) begin
                            w_state_next = ST_IDLE;
                        end else begin
                            w_state_next = ST_DATA;
                            w_os_clr     = 1'b1;
                            w_bit_clr    = 1'b1;
                        end
                    end else begin
                        w_os_inc = 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_os_cnt == c_OS_LAST) begin
                        w_shift  = 1'b1;
                        w_os_clr = 1'b1;
                        if (r_bit_cnt == c_BIT_LAST)
                            w_state_next = c_PAR_EN ? ST_PARITY : ST_STOP;
                    end else begin
                        w_os_inc = 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (r_os_cnt == c_OS_LAST) begin
                        w_par_chk    = 1'b1;
                        w_os_clr     = 1'b1;
                        w_state_next = ST_STOP;
                    end else begin
                        w_os_inc = 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_os_cnt == c_OS_LAST) begin
                        w_os_clr = 1'b1;
                        if (w_rx_s) begin
                            w_state_next = ST_IDLE;
                            if (r_par_ok) w_load = 1'b1;
                            else          w_perr = 1'b1;
                        end else begin
                            w_state_next = ST_BREAK;
                            w_ferr       = 1'b1;
                        end
                    end else begin
                        w_os_inc = 1'b1;
                    end
                end
                ST_BREAK: begin
                    // A held-low line must not look like a new start bit
                    if (w_rx_s) w_state_next = ST_IDLE;
                end
                default: w_state_next = ST_IDLE;
            endcase
        end
    end

    // Oversample/bit counters, shift register and parity result
    always_ff @(posedge clk) begin
        if (rst) begin
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
            r_par_ok  <= 1'b1;
        end else begin
            if (w_os_clr)      r_os_cnt <= '0;
            else if (w_os_inc) r_os_cnt <= r_os_cnt + c_OW'(1);
            if (w_bit_clr) begin
                r_bit_cnt <= '0;
                r_par_ok  <= 1'b1;
            end else if (w_shift) begin
                r_bit_cnt <= r_bit_cnt + c_BW'(1);
            end
            // Line order is LSB first, so new bits enter at the MSB
            if (w_shift)   r_shift  <= {w_rx_s, r_shift[DATA_BITS-1:1]};
            if (w_par_chk) r_par_ok <= (w_rx_s == w_exp_par);
        end
    end

    // Output word register, handshake and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= w_ferr;
            r_parity_err <= w_perr;
            r_overrun    <= w_load & r_rx_valid & ~io_bus.rx_ready;
            if (w_load) begin
                r_rx_data  <= r_shift;
                r_rx_valid <= 1'b1;
            end else if (w_accept) begin
                r_rx_valid <= 1'b0;
            end
        end
    end

    assign io_bus.rx_data    = r_rx_data;
    assign io_bus.rx_valid   = r_rx_valid;
    assign io_bus.frame_err  = r_frame_err;
    assign io_bus.parity_err = r_parity_err;
    assign io_bus.overrun    = r_overrun;
    assign io_bus.busy       = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_oversampled.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_oversampled
//  Description : Directed self-checking bench for uart_rx_oversampled
//                (8N1 instance plus an 8E1 instance on its own line).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_uart_rx_oversampled;

    localparam int c_CLK_HALF = 5;
    localparam int c_OS_HALF  = 4 * 2 * c_CLK_HALF;  // os period = 8 clk
    localparam int c_BIT      = 8 * 2 * c_OS_HALF;   // bit = 8 os periods

    logic clk    = 1'b0;
    logic rst    = 1'b1;
    logic os_clk = 1'b0;
    logic rx     = 1'b1;
    logic rx_p   = 1'b1;
    logic sel_p  = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    uart_rx_oversampled_if #(.DATA_BITS(8)) u_bus ();
    uart_rx_oversampled_if #(.DATA_BITS(8)) u_bus_p ();

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(0), .PARITY_ODD(0)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .os_clk (os_clk),
        .rx     (rx),
        .io_bus (u_bus.master)
    );

    uart_rx_oversampled #(
        .DATA_BITS(8), .OVERSAMPLE(8), .PARITY_EN(1), .PARITY_ODD(0)
    ) u_dut_p (
        .clk    (clk),
        .rst    (rst),
        .os_clk (os_clk),
        .rx     (rx_p),
        .io_bus (u_bus_p.master)
    );

    always #(c_CLK_HALF) clk = ~clk;
    always #(c_OS_HALF)  os_clk = ~os_clk;

    // Event counters for the 8N1 instance, sampled away from the active edge
    int         n_vrise = 0;
    int         n_vcyc  = 0;
    int         n_ferr  = 0;
    int         n_perr  = 0;
    int         n_ovr   = 0;
    int         n_busy  = 0;
    logic       prev_v  = 1'b0;
    logic [7:0] last_d  = 8'h00;

    always @(negedge clk) begin
        if (u_bus.rx_valid && !prev_v) begin
            n_vrise = n_vrise + 1;
            last_d  = u_bus.rx_data;
        end
        if (u_bus.rx_valid)   n_vcyc = n_vcyc + 1;
        if (u_bus.frame_err)  n_ferr = n_ferr + 1;
        if (u_bus.parity_err) n_perr = n_perr + 1;
        if (u_bus.overrun)    n_ovr  = n_ovr + 1;
        if (u_bus.busy)       n_busy = n_busy + 1;
        prev_v = u_bus.rx_valid;
    end

    // Event counters for the parity instance
    int         p_vrise = 0;
    int         p_perr  = 0;
    logic       p_prev  = 1'b0;
    logic [7:0] p_last  = 8'h00;

    always @(negedge clk) begin
        if (u_bus_p.rx_valid && !p_prev) begin
            p_vrise = p_vrise + 1;
            p_last  = u_bus_p.rx_data;
        end
        if (u_bus_p.parity_err) p_perr = p_perr + 1;
        p_prev = u_bus_p.rx_valid;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic b);
        if (sel_p) rx_p = b;
        else       rx   = b;
    endtask

    // Start, 8 data bits LSB first, optional parity, stop; line left at stop level
    task automatic send_frame(input logic [7:0] d, input logic has_par,
                              input logic par, input logic stop);
        drive(1'b0);
        #(c_BIT);
        for (int i = 0; i < 8; i++) begin
            drive(d[i]);
            #(c_BIT);
        end
        if (has_par) begin
            drive(par);
            #(c_BIT);
        end
        drive(stop);
        #(c_BIT);
    endtask

    int snap_busy;

    initial begin
        u_bus.rx_ready   = 1'b1;
        u_bus_p.rx_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #(c_BIT);

        // Reset state
        check("rst_valid", {31'd0, u_bus.rx_valid}, 32'd0);
        check("rst_busy",  {31'd0, u_bus.busy},     32'd0);
        check("rst_data",  {24'd0, u_bus.rx_data},  32'd0);

        // 1: 8N1 0xA5 with ready held high
        send_frame(8'hA5, 1'b0, 1'b0, 1'b1);
        #(2 * c_BIT);
        check("t1_vrise", n_vrise, 1);
        check("t1_vcyc",  n_vcyc,  1);
        check("t1_data",  {24'd0, last_d}, 32'hA5);
        check("t1_ferr",  n_ferr,  0);
        check("t1_perr",  n_perr,  0);
        check("t1_ovr",   n_ovr,   0);

        // 2: short low glitch is rejected
        snap_busy = n_busy;
        drive(1'b0);
        #(2 * 2 * c_OS_HALF);
        drive(1'b1);
        #(4 * 2 * c_OS_HALF);
        check("t2_busy_seen", {31'd0, (n_busy > snap_busy)}, 32'd1);
        check("t2_busy",      {31'd0, u_bus.busy}, 32'd0);
        check("t2_vrise",     n_vrise, 1);
        check("t2_ferr",      n_ferr,  0);
        #(2 * c_BIT);

        // 3: stop low, line held low 20 bits -> one frame error, then recovery
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
        #(10 * c_BIT);
        check("t3_ferr_hold", n_ferr, 1);
        check("t3_busy_hold", {31'd0, u_bus.busy}, 32'd1);
        #(10 * c_BIT);
        drive(1'b1);
        #(2 * c_BIT);
        check("t3_busy_idle", {31'd0, u_bus.busy}, 32'd0);
        check("t3_ferr_once", n_ferr,  1);
        check("t3_no_valid",  n_vrise, 1);
        send_frame(8'h55, 1'b0, 1'b0, 1'b1);
        #(2 * c_BIT);
        check("t3_vrise", n_vrise, 2);
        check("t3_vcyc",  n_vcyc,  2);
        check("t3_data",  {24'd0, last_d}, 32'h55);

        // 4: overrun with consumer stalled, then accept
        @(negedge clk);
        u_bus.rx_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b0, 1'b1);
        #(c_BIT);
        check("t4_first", {24'd0, u_bus.rx_data}, 32'h11);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1);
        #(c_BIT);
        @(negedge clk);
        check("t4_ovr",   n_ovr, 1);
        check("t4_data",  {24'd0, u_bus.rx_data}, 32'h22);
        check("t4_valid", {31'd0, u_bus.rx_valid}, 32'd1);
        check("t4_vrise", n_vrise, 3);
        u_bus.rx_ready = 1'b1;
        @(posedge clk);
        #1;
        check("t4_accept", {31'd0, u_bus.rx_valid}, 32'd0);
        #(2 * c_BIT);

        // 5: reset during bit 3 of 0xF0, then 0x0F
        drive(1'b0);
        #(c_BIT);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0);
            #(c_BIT);
        end
        drive(1'b0);
        #(c_BIT / 2);
        @(negedge clk);
        check("t5_busy_pre", {31'd0, u_bus.busy}, 32'd1);
        rst = 1'b1;
        drive(1'b1);
        @(posedge clk);
        #1;
        check("t5_busy",  {31'd0, u_bus.busy},     32'd0);
        check("t5_valid", {31'd0, u_bus.rx_valid}, 32'd0);
        check("t5_data",  {24'd0, u_bus.rx_data},  32'd0);
        @(negedge clk);
        rst = 1'b0;
        #(2 * c_BIT);
        send_frame(8'h0F, 1'b0, 1'b0, 1'b1);
        #(2 * c_BIT);
        check("t5_vrise", n_vrise, 4);
        check("t5_rx",    {24'd0, last_d}, 32'h0F);

        // 6: even parity; 0x07 has three ones so parity bit must be 1
        sel_p = 1'b1;
        send_frame(8'h07, 1'b1, 1'b0, 1'b1);
        #(2 * c_BIT);
        check("t6_perr",     p_perr,  1);
        check("t6_no_valid", p_vrise, 0);
        send_frame(8'h07, 1'b1, 1'b1, 1'b1);
        #(2 * c_BIT);
        check("t6_vrise", p_vrise, 1);
        check("t6_data",  {24'd0, p_last}, 32'h07);
        check("t6_perr2", p_perr,  1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
